// File: rtl/y_zigzag_rle.sv
// rtl/y_zigzag_rle.sv - captures a quantized 8x8 luma block, walks it in zig-zag order, emits DC/AC/ZRL/EOB symbols.
// Optional macro Y_ZZ_DBUF_EN adds a second holding buffer so a block can arrive while the previous one drains.
module y_zigzag_rle #(
  parameter int DATA_W = 11,
  parameter int RUN_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blk_valid,
  input  logic [64*DATA_W-1:0]   blk_in,
  output logic                   blk_ready,
  output logic                   sym_valid,
  input  logic                   sym_ready,
  output logic [1:0]             sym_type,
  output logic [RUN_W-1:0]       sym_run,
  output logic [DATA_W-1:0]      sym_val,
  output logic                   sym_last,
  output logic                   drop
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DC, S_AC, S_EOB} state_t;

  localparam logic [1:0] T_DC  = 2'b00;
  localparam logic [1:0] T_AC  = 2'b01;
  localparam logic [1:0] T_ZRL = 2'b10;
  localparam logic [1:0] T_EOB = 2'b11;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t             state, state_n;
  logic [DATA_W-1:0]  act_buf [64];
  logic [5:0]         last_nz, last_nz_scan;
  logic [6:0]         idx, idx_n;
  logic [RUN_W-1:0]   run, run_n;
  logic               sym_valid_n, sym_last_n;
  logic [1:0]         sym_type_n;
  logic [RUN_W-1:0]   sym_run_n;
  logic [DATA_W-1:0]  sym_val_n;
  logic [DATA_W-1:0]  cur;
  logic               accept_blk, slot_free, leave, to_load;

  assign cur        = act_buf[ZZ[idx[5:0]]];
  assign slot_free  = !sym_valid || sym_ready;
  assign accept_blk = blk_valid && blk_ready;

`ifdef Y_ZZ_DBUF_EN
  logic [DATA_W-1:0] hold_buf [64];
  logic              hold_full;
  assign blk_ready = !hold_full;
  // A block arriving in the same cycle as the final accept skips the hold buffer.
  assign to_load   = hold_full || accept_blk;
`else
  assign blk_ready = (state == S_IDLE);
  assign to_load   = 1'b0;
`endif

  always_comb begin
    last_nz_scan = '0;
    for (int i = 1; i < 64; i++)
      if (act_buf[ZZ[i]] != '0) last_nz_scan = 6'(i);
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    run_n       = run;
    sym_valid_n = sym_valid && !sym_ready;
    sym_type_n  = sym_type;
    sym_run_n   = sym_run;
    sym_val_n   = sym_val;
    sym_last_n  = sym_last;
    leave       = 1'b0;
    case (state)
      S_IDLE: if (accept_blk) state_n = S_LOAD;
      S_LOAD: state_n = S_DC;
      S_DC: begin
        if (!sym_valid) begin
          sym_valid_n = 1'b1; sym_type_n = T_DC; sym_run_n = '0;
          sym_val_n = act_buf[0]; sym_last_n = 1'b0;
        end else if (sym_ready) begin
          state_n = S_AC; idx_n = 7'd1; run_n = '0;
        end
      end
      S_AC: begin
        // idx==64 means index 63 was emitted and only its accept is outstanding.
        if (idx[6]) begin
          if (sym_valid && sym_ready) leave = 1'b1;
        end else if (slot_free) begin
          idx_n = idx + 7'd1;
          if (idx[5:0] > last_nz) begin
            state_n = S_EOB;
            idx_n   = idx;
          end else if (cur != '0) begin
            sym_valid_n = 1'b1; sym_type_n = T_AC; sym_run_n = run;
            sym_val_n = cur; sym_last_n = (idx[5:0] == 6'd63);
            run_n = '0;
          end else if (run == RUN_MAX) begin
            sym_valid_n = 1'b1; sym_type_n = T_ZRL; sym_run_n = RUN_MAX;
            sym_val_n = '0; sym_last_n = 1'b0;
            run_n = '0;
          end else begin
            run_n = run + RUN_W'(1);
          end
        end
      end
      S_EOB: begin
        if (!sym_valid) begin
          sym_valid_n = 1'b1; sym_type_n = T_EOB; sym_run_n = '0;
          sym_val_n = '0; sym_last_n = 1'b1;
        end else if (sym_ready) begin
          leave = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (leave) state_n = to_load ? S_LOAD : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      run       <= '0;
      last_nz   <= '0;
      sym_valid <= 1'b0;
      sym_type  <= '0;
      sym_run   <= '0;
      sym_val   <= '0;
      sym_last  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      run       <= run_n;
      sym_valid <= sym_valid_n;
      sym_type  <= sym_type_n;
      sym_run   <= sym_run_n;
      sym_val   <= sym_val_n;
      sym_last  <= sym_last_n;
      drop      <= blk_valid && !blk_ready;
      if (state == S_LOAD) last_nz <= last_nz_scan;
    end
  end

`ifdef Y_ZZ_DBUF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
    end else if (leave) begin
      hold_full <= 1'b0;
    end else if (accept_blk && state != S_IDLE) begin
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_blk && (state == S_IDLE || leave)) begin
      for (int i = 0; i < 64; i++) act_buf[i] <= blk_in[i*DATA_W +: DATA_W];
    end else if (leave && hold_full) begin
      for (int i = 0; i < 64; i++) act_buf[i] <= hold_buf[i];
    end
    if (accept_blk && !(state == S_IDLE || leave)) begin
      for (int i = 0; i < 64; i++) hold_buf[i] <= blk_in[i*DATA_W +: DATA_W];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (accept_blk)
      for (int i = 0; i < 64; i++) act_buf[i] <= blk_in[i*DATA_W +: DATA_W];
  end
`endif

endmodule

// File: tb/tb_y_zigzag_rle.sv
// tb/tb_y_zigzag_rle.sv - scoreboard bench for y_zigzag_rle with a diagonal-walk reference model.
module tb_y_zigzag_rle;

  localparam int DW = 11;

  typedef struct packed {
    logic [1:0]  t;
    logic [3:0]  r;
    logic [10:0] v;
    logic        l;
  } sym_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            blk_valid = 1'b0;
  logic [64*DW-1:0] blk_in = '0;
  logic            blk_ready;
  logic            sym_valid;
  logic            sym_ready = 1'b1;
  logic [1:0]      sym_type;
  logic [3:0]      sym_run;
  logic [DW-1:0]   sym_val;
  logic            sym_last;
  logic            drop;

  int   checks = 0;
  int   errors = 0;
  int   drop_cnt = 0;
  int   ready_mode = 0;
  int   zz_pos [64];
  int   cur_blk [64];
  sym_t exp_q [$];

  y_zigzag_rle #(.DATA_W(DW), .RUN_W(4)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_in(blk_in), .blk_ready(blk_ready),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_type(sym_type), .sym_run(sym_run),
    .sym_val(sym_val), .sym_last(sym_last), .drop(drop)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: sym_ready = 1'b1;
        1: sym_ready = ($urandom_range(0, 3) != 0);
        default: sym_ready = ~sym_ready;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accept and checks stability while stalled.
  sym_t prev_sym;
  logic stall_prev = 1'b0;
  always @(negedge clk) begin
    sym_t got, e;
    got = '{t: sym_type, r: sym_run, v: sym_val, l: sym_last};
    if (drop) drop_cnt++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!sym_valid || got != prev_sym) begin
          errors++;
          $display("FAIL stall_stable: got valid=%0b sym=%h required valid=1 sym=%h", sym_valid, got, prev_sym);
        end
      end
      if (sym_valid && sym_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_symbol: got t=%0d r=%0d v=%0d l=%0b required none", sym_type, sym_run, sym_val, sym_last);
        end else begin
          e = exp_q.pop_front();
          if (got != e) begin
            errors++;
            $display("FAIL symbol: got t=%0d r=%0d v=%h l=%0b required t=%0d r=%0d v=%h l=%0b",
                     got.t, got.r, got.v, got.l, e.t, e.r, e.v, e.l);
          end
        end
      end
      stall_prev = sym_valid && !sym_ready;
      prev_sym   = got;
    end
  end

  function automatic void build_zz_pos();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz_pos[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz_pos[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  function automatic void push_expected();
    int   last = 0;
    int   run  = 0;
    sym_t e;
    for (int k = 1; k < 64; k++) if (cur_blk[zz_pos[k]] != 0) last = k;
    e.t = 2'd0; e.r = 4'd0; e.v = 11'(cur_blk[zz_pos[0]]); e.l = 1'b0;
    exp_q.push_back(e);
    for (int k = 1; k <= last; k++) begin
      int x = cur_blk[zz_pos[k]];
      if (x != 0) begin
        e.t = 2'd1; e.r = 4'(run); e.v = 11'(x); e.l = (k == 63);
        exp_q.push_back(e);
        run = 0;
      end else if (run == 15) begin
        e.t = 2'd2; e.r = 4'd15; e.v = '0; e.l = 1'b0;
        exp_q.push_back(e);
        run = 0;
      end else begin
        run++;
      end
    end
    if (last < 63) begin
      e.t = 2'd3; e.r = 4'd0; e.v = '0; e.l = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void clear_blk();
    for (int i = 0; i < 64; i++) cur_blk[i] = 0;
  endfunction

  function automatic void pack_blk();
    for (int i = 0; i < 64; i++) blk_in[i*DW +: DW] = 11'(cur_blk[i]);
  endfunction

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic send_block();
    int n = 0;
    while (!blk_ready && n < 3000) begin @(posedge clk); #1; n++; end
    check("send_ready_timeout", int'(blk_ready), 1);
    pack_blk();
    push_expected();
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !blk_ready) && n < 5000) begin @(posedge clk); #1; n++; end
    check(name, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_q_below(input int lim);
    int n = 0;
    while (exp_q.size() >= lim && n < 3000) begin @(posedge clk); #1; n++; end
    check("wait_progress_timeout", int'(exp_q.size() < lim), 1);
  endtask

  initial begin
    int d0;
    build_zz_pos();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_blk_ready", int'(blk_ready), 1);
    check("reset_sym_valid", int'(sym_valid), 0);
    check("reset_sym_type", int'(sym_type), 0);
    check("reset_sym_run", int'(sym_run), 0);
    check("reset_sym_val", int'(sym_val), 0);
    check("reset_sym_last", int'(sym_last), 0);
    check("reset_drop", int'(drop), 0);

    // All zero block plus DC latency.
    clear_blk();
    send_block();
    check("lat_after_accept", int'(sym_valid), 0);
    @(posedge clk); #1;
    check("lat_one_cycle", int'(sym_valid), 0);
    @(posedge clk); #1;
    check("lat_two_cycles", int'(sym_valid), 1);
    wait_done("all_zero_done");

    clear_blk(); cur_blk[zz_pos[0]] = -5; cur_blk[zz_pos[3]] = 7;
    send_block(); wait_done("dc_neg_done");

    clear_blk(); cur_blk[zz_pos[20]] = 1;
    send_block(); wait_done("zrl_done");

    clear_blk(); cur_blk[zz_pos[63]] = 2;
    send_block(); wait_done("last63_done");

    for (int i = 0; i < 64; i++) cur_blk[i] = 1;
    send_block(); wait_done("all_ones_done");

    ready_mode = 2;
    send_block(); wait_done("toggle_done");

    ready_mode = 1;
    for (int b = 0; b < 20; b++) begin
      int dens = (b % 3 == 0) ? 15 : 3;
      for (int i = 0; i < 64; i++)
        cur_blk[i] = ($urandom_range(0, dens) == 0) ? int'($urandom_range(0, 2047)) - 1024 : 0;
      send_block();
      wait_done("random_done");
    end

    // Second block arrives during AC.
    ready_mode = 0;
    for (int i = 0; i < 64; i++) cur_blk[i] = 1;
    send_block();
    wait_q_below(55);
    d0 = drop_cnt;
    clear_blk(); cur_blk[zz_pos[0]] = 9; cur_blk[zz_pos[5]] = -3;
    pack_blk();
`ifdef Y_ZZ_DBUF_EN
    check("dbuf_ready_busy", int'(blk_ready), 1);
    push_expected();
`else
    check("busy_not_ready", int'(blk_ready), 0);
`endif
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    wait_done("drop_test_done");
`ifdef Y_ZZ_DBUF_EN
    check("drop_count", drop_cnt - d0, 0);
`else
    check("drop_count", drop_cnt - d0, 1);
`endif

    // Reset mid-AC.
    ready_mode = 1;
    for (int i = 0; i < 64; i++) cur_blk[i] = 1;
    send_block();
    wait_q_below(50);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_sym_valid", int'(sym_valid), 0);
    check("midrst_blk_ready", int'(blk_ready), 1);
    check("midrst_sym_last", int'(sym_last), 0);
    ready_mode = 0;
    clear_blk(); cur_blk[zz_pos[0]] = 100; cur_blk[zz_pos[40]] = -1;
    send_block(); wait_done("after_reset_done");

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
